// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and constants for the trace capture unit
// Contents: event type codes, capture FSM states and the record layout.
package trace_pkg;

    localparam int TYPE_W    = 3;
    localparam int NUM_TYPES = 6;

    typedef enum logic [TYPE_W-1:0] {
        T_REGW  = 3'd0,
        T_BR_NT = 3'd1,
        T_BR_T  = 3'd2,
        T_CALL  = 3'd3,
        T_RET   = 3'd4,
        T_HLT   = 3'd5
    } ev_type_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_FROZEN  = 2'd2
    } state_t;

    // Record layout for the default 16-bit data / 16-bit stamp build.
    typedef struct packed {
        ev_type_t    ev_type;
        logic [15:0] pc;
        logic [15:0] value;
        logic [15:0] cycle;
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - circular record buffer with optional overwrite of the oldest entry
// Ports: clk, rst (async active-low), clear (sync flush), push/pop/overwrite_en,
//        wr_data in; head (oldest record), count, full, empty out.
module trace_fifo #(
    parameter int WIDTH = 51,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     overwrite_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             do_pop;
    logic             do_push;
    logic             do_over;

    assign full  = (cnt == (PTR_W+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign head  = mem[rd_ptr];
    assign count = cnt;

    // A same-cycle pop frees a slot, so a full push with a pop is a plain push.
    assign do_pop  = pop & ~empty & ~clear;
    assign do_over = push & full & ~do_pop & overwrite_en & ~clear;
    assign do_push = push & ~clear & (~full | do_pop | overwrite_en);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // Overwrite drops the oldest entry by moving the read side along.
            if (do_pop | do_over) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push & ~do_over, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/trace_capture_unit.sv
// rtl/trace_capture_unit.sv - retire-event trace recorder with time stamps and drain port
// Ports: clk, rst (async active-low); ev_* retire strobes and fields; cfg_* capture
//        configuration; clear (sync flush); rd_valid/rd_ready/rd_data drain port;
//        count occupancy, drop_cnt lost events, state capture FSM state.
module trace_capture_unit
    import trace_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int CYC_W  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ev_regw,
    input  logic                             ev_branch,
    input  logic                             ev_call,
    input  logic                             ev_ret,
    input  logic                             ev_hlt,
    input  logic                             ev_taken,
    input  logic [ADDR_W-1:0]                ev_reg_addr,
    input  logic [DATA_W-1:0]                ev_reg_data,
    input  logic [DATA_W-1:0]                ev_pc,
    input  logic [DATA_W-1:0]                ev_target,
    input  logic                             cfg_en,
    input  logic                             cfg_mode,
    input  logic [5:0]                       cfg_mask,
    input  logic [5:0]                       cfg_trig_mask,
    input  logic                             clear,
    output logic                             rd_valid,
    input  logic                             rd_ready,
    output logic [TYPE_W+2*DATA_W+CYC_W-1:0] rd_data,
    output logic [$clog2(DEPTH):0]           count,
    output logic [7:0]                       drop_cnt,
    output logic [1:0]                       state
);
    localparam int REC_W = TYPE_W + 2*DATA_W + CYC_W;

    logic [NUM_TYPES-1:0] ev_en;
    logic                 win_valid;
    logic [TYPE_W-1:0]    win_type;
    logic [DATA_W-1:0]    win_pc;
    logic [DATA_W-1:0]    win_value;
    logic [2:0]           num_en;
    logic [2:0]           win_losers;

    // Sample-stage registers: the arbitrated event is held one cycle before commit.
    logic                 s_valid;
    logic [TYPE_W-1:0]    s_type;
    logic [DATA_W-1:0]    s_pc;
    logic [DATA_W-1:0]    s_value;
    logic [CYC_W-1:0]     s_stamp;
    logic [2:0]           s_losers;

    logic [CYC_W-1:0]     cyc;
    logic [1:0]           state_q;
    logic [7:0]           drop_q;
    logic [REC_W-1:0]     head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 accept;
    logic                 full_drop;
    logic                 push;
    logic [8:0]           drop_sum;

    always_comb begin
        ev_en          = '0;
        ev_en[T_REGW]  = ev_regw;
        ev_en[T_BR_NT] = ev_branch & ~ev_taken;
        ev_en[T_BR_T]  = ev_branch & ev_taken;
        ev_en[T_CALL]  = ev_call;
        ev_en[T_RET]   = ev_ret;
        ev_en[T_HLT]   = ev_hlt;
        ev_en          = ev_en & cfg_mask;
    end

    always_comb begin
        win_valid = |ev_en;
        win_type  = T_REGW;
        if (ev_en[T_HLT])        win_type = T_HLT;
        else if (ev_en[T_CALL])  win_type = T_CALL;
        else if (ev_en[T_RET])   win_type = T_RET;
        else if (ev_en[T_BR_T])  win_type = T_BR_T;
        else if (ev_en[T_BR_NT]) win_type = T_BR_NT;
        num_en = '0;
        for (int i = 0; i < NUM_TYPES; i++) begin
            num_en = num_en + {2'b00, ev_en[i]};
        end
        win_losers = win_valid ? (num_en - 3'd1) : 3'd0;
        win_pc     = ev_pc;
        win_value  = ev_target;
        case (win_type)
            T_REGW: begin
                win_pc    = DATA_W'(ev_reg_addr);
                win_value = ev_reg_data;
            end
            T_BR_NT, T_HLT: win_value = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc      <= '0;
            s_valid  <= 1'b0;
            s_type   <= '0;
            s_pc     <= '0;
            s_value  <= '0;
            s_stamp  <= '0;
            s_losers <= '0;
        end else begin
            cyc      <= cyc + CYC_W'(1);
            s_valid  <= win_valid & ~clear;
            s_type   <= win_type;
            s_pc     <= win_pc;
            s_value  <= win_value;
            s_stamp  <= cyc;
            s_losers <= win_losers;
        end
    end

    assign rd_valid  = ~fifo_empty;
    assign rd_data   = fifo_empty ? '0 : head;
    assign pop       = rd_valid & rd_ready;
    assign accept    = s_valid & cfg_en &
                       ((state_q == S_CAPTURE) |
                        ((state_q == S_IDLE) & cfg_trig_mask[s_type]));
    assign full_drop = accept & fifo_full & ~pop & ~cfg_mode;
    assign push      = accept & ~full_drop & ~clear;
    assign drop_sum  = {1'b0, drop_q} + {6'd0, (accept ? s_losers : 3'd0)} + {8'd0, full_drop};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            drop_q  <= '0;
        end else if (clear) begin
            state_q <= S_IDLE;
            drop_q  <= '0;
        end else begin
            drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q <= (s_type == T_HLT) ? S_FROZEN : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (!cfg_en) begin
                        state_q <= S_IDLE;
                    end else if (accept && s_type == T_HLT) begin
                        state_q <= S_FROZEN;
                    end
                end
                default: state_q <= S_FROZEN;
            endcase
        end
    end

    assign drop_cnt = drop_q;
    assign state    = state_q;

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .push         (push),
        .pop          (pop),
        .overwrite_en (cfg_mode),
        .wr_data      ({s_type, s_pc, s_value, s_stamp}),
        .head         (head),
        .count        (count),
        .full         (fifo_full),
        .empty        (fifo_empty)
    );

endmodule

// File: tb/tb_trace_capture_unit.sv
// tb/tb_trace_capture_unit.sv - directed scoreboard bench for trace_capture_unit
module tb_trace_capture_unit;
    import trace_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;
    localparam int CYC_W  = 16;
    localparam int REC_W  = TYPE_W + 2*DATA_W + CYC_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              ev_regw, ev_branch, ev_call, ev_ret, ev_hlt, ev_taken;
    logic [ADDR_W-1:0] ev_reg_addr;
    logic [DATA_W-1:0] ev_reg_data, ev_pc, ev_target;
    logic              cfg_en, cfg_mode;
    logic [5:0]        cfg_mask, cfg_trig_mask;
    logic              clear;
    logic              rd_valid, rd_ready;
    logic [REC_W-1:0]  rd_data;
    logic [2:0]        count;
    logic [7:0]        drop_cnt;
    logic [1:0]        state;

    logic [CYC_W-1:0]  tb_cyc;
    logic [REC_W-1:0]  exp_q[$];
    int                exp_drop = 0;
    int                vectors = 0;
    int                miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) tb_cyc <= '0;
        else      tb_cyc <= tb_cyc + 1'b1;
    end

    trace_capture_unit #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .DEPTH (DEPTH), .CYC_W (CYC_W)
    ) dut (
        .clk (clk), .rst (rst),
        .ev_regw (ev_regw), .ev_branch (ev_branch), .ev_call (ev_call),
        .ev_ret (ev_ret), .ev_hlt (ev_hlt), .ev_taken (ev_taken),
        .ev_reg_addr (ev_reg_addr), .ev_reg_data (ev_reg_data),
        .ev_pc (ev_pc), .ev_target (ev_target),
        .cfg_en (cfg_en), .cfg_mode (cfg_mode), .cfg_mask (cfg_mask),
        .cfg_trig_mask (cfg_trig_mask), .clear (clear),
        .rd_valid (rd_valid), .rd_ready (rd_ready), .rd_data (rd_data),
        .count (count), .drop_cnt (drop_cnt), .state (state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REC_W-1:0] mk_rec(input logic [2:0] t, input logic [15:0] pc,
                                                input logic [15:0] val, input logic [15:0] st);
        trace_rec_t r;
        r.ev_type = ev_type_t'(t);
        r.pc      = pc;
        r.value   = val;
        r.cycle   = st;
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_ev();
        ev_regw = 0; ev_branch = 0; ev_call = 0; ev_ret = 0; ev_hlt = 0; ev_taken = 0;
    endtask

    task automatic exp_push(input logic [REC_W-1:0] r);
        if (exp_q.size() < DEPTH) exp_q.push_back(r);
        else if (cfg_mode) begin
            exp_q.delete(0);
            exp_q.push_back(r);
        end else exp_drop++;
    endtask

    // Drives a single event for one cycle; a = pc (or reg addr), b = target (or reg data).
    task automatic send(input logic [2:0] t, input logic [15:0] a, input logic [15:0] b, input bit rec);
        logic [15:0] pc_e, val_e;
        ev_regw = (t == 0); ev_branch = (t == 1 || t == 2); ev_taken = (t == 2);
        ev_call = (t == 3); ev_ret = (t == 4); ev_hlt = (t == 5);
        ev_reg_addr = a[3:0]; ev_reg_data = b; ev_target = b;
        ev_pc = (t == 0) ? (a ^ 16'h5A5A) : a;
        pc_e  = (t == 0) ? {12'h000, a[3:0]} : a;
        val_e = (t == 1 || t == 5) ? 16'h0000 : b;
        if (rec) exp_push(mk_rec(t, pc_e, val_e, tb_cyc));
        tick();
        idle_ev();
    endtask

    task automatic drain(input int n);
        logic [REC_W-1:0] e;
        for (int k = 0; k < n; k++) begin
            e = '1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            chk("drain_valid", rd_valid, 1);
            chk("drain_data", rd_data, e);
            rd_ready = 1;
            tick();
            rd_ready = 0;
        end
    endtask

    task automatic clear_all();
        clear = 1;
        tick();
        clear = 0;
        exp_q.delete();
        exp_drop = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [15:0] st;
        logic [REC_W-1:0] nrec;
        rst = 0; clear = 0; rd_ready = 0; idle_ev();
        ev_reg_addr = '0; ev_reg_data = '0; ev_pc = '0; ev_target = '0;
        cfg_en = 1; cfg_mode = 0; cfg_mask = 6'h3F; cfg_trig_mask = 6'b000001;
        tick(); tick();
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_count", count, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_state", state, 0);
        rst = 1;

        // Trigger on a register write stamped with cycle 5.
        for (int k = 0; k < 40 && tb_cyc != 16'd5; k++) tick();
        chk("reach_cycle5", tb_cyc, 5);
        send(3'd0, 16'h0003, 16'hBEEF, 1);
        chk("no_bypass_valid", rd_valid, 0);
        tick();
        chk("t1_data", rd_data, {3'd0, 16'h0003, 16'hBEEF, 16'd5});
        chk("t1_state", state, 1);
        drain(1);

        // CALL beats a same-cycle REGW; the REGW is a drop.
        ev_call = 1; ev_pc = 16'h0010; ev_target = 16'h0040;
        ev_regw = 1; ev_reg_addr = 4'h7; ev_reg_data = 16'h1234;
        exp_q.push_back(mk_rec(3'd3, 16'h0010, 16'h0040, tb_cyc));
        tick(); idle_ev(); tick();
        chk("t2_drop", drop_cnt, 1);
        chk("t2_count", count, 1);
        drain(1);
        chk("t2_empty", rd_valid, 0);

        // Stop-when-full: six writes into four slots.
        cfg_trig_mask = 6'h3F;
        clear_all();
        chk("clr_count", count, 0);
        chk("clr_drop", drop_cnt, 0);
        chk("clr_state", state, 0);
        for (int i = 0; i < 6; i++) send(3'd0, 16'(i + 1), 16'(16'h1000 + i), 1);
        tick();
        chk("t3_count", count, 4);
        chk("t3_drop", drop_cnt, exp_drop);
        drain(4);

        // Circular overwrite keeps the newest four.
        clear_all();
        cfg_mode = 1;
        send(3'd0, 16'h0009, 16'hA001, 1);
        send(3'd1, 16'h0100, 16'hA002, 1);
        send(3'd2, 16'h0104, 16'hA003, 1);
        send(3'd3, 16'h0108, 16'hA004, 1);
        send(3'd4, 16'h010C, 16'hA005, 1);
        send(3'd0, 16'h000A, 16'hA006, 1);
        tick();
        chk("t4_count", count, 4);
        chk("t4_drop", drop_cnt, 0);
        drain(4);

        // HLT freezes capture; later events are ignored.
        clear_all();
        cfg_mode = 0;
        send(3'd0, 16'h0002, 16'h5555, 1);
        send(3'd5, 16'h0022, 16'h7777, 1);
        send(3'd0, 16'h0004, 16'h6666, 0);
        send(3'd3, 16'h0030, 16'h0031, 0);
        send(3'd2, 16'h0032, 16'h0033, 0);
        tick();
        chk("t5_state", state, 2);
        chk("t5_count", count, 2);
        chk("t5_drop", drop_cnt, 0);
        drain(1);
        chk("t5_hlt_last", rd_data, (exp_q.size() > 0) ? exp_q[0] : '1);
        chk("t5_hlt_count", count, 1);
        clear_all();
        chk("t5_clr_count", count, 0);
        chk("t5_clr_state", state, 0);
        chk("t5_clr_valid", rd_valid, 0);

        // Full buffer in stop mode: push and pop in the same cycle.
        for (int i = 0; i < 4; i++) send(3'd4, 16'(16'h0200 + i), 16'(16'h0300 + i), 1);
        tick();
        chk("t6_full", count, 4);
        st = tb_cyc;
        send(3'd0, 16'h000C, 16'hCAFE, 0);
        nrec = mk_rec(3'd0, 16'h000C, 16'hCAFE, st);
        chk("t6_head", rd_data, exp_q[0]);
        rd_ready = 1;
        exp_q.delete(0);
        exp_q.push_back(nrec);
        tick();
        rd_ready = 0;
        chk("t6_count", count, 4);
        chk("t6_drop", drop_cnt, 0);
        drain(4);

        // Asynchronous reset mid-capture.
        send(3'd3, 16'h0400, 16'h0404, 1);
        tick();
        chk("t7_pre_valid", rd_valid, 1);
        #2 rst = 0;
        #1;
        chk("t7_valid", rd_valid, 0);
        chk("t7_data", rd_data, 0);
        chk("t7_count", count, 0);
        chk("t7_state", state, 0);
        chk("t7_drop", drop_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
